// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store sequencer between the execute stage and a single-port data
//   memory with a req/ack handshake. One operation is in flight at a time.
//   Requests are decoded in IDLE: non-memory ops and illegal/misaligned
//   accesses answer directly; legal accesses drive a registered memory
//   request, wait for mem_ack (bounded by MAX_WAIT cycles) and answer with
//   lane-extracted, sign/zero-extended load data.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   req_op, req_func3           opcode and width/sign selector
//   req_addr, req_wdata         byte address, store data / pass-through value
//   mem_req/we/addr/be/wdata    registered memory request, held until mem_ack
//   mem_ack, mem_rdata          memory completion and read word
//   rsp_valid/data/err          one-cycle response pulse with held data/error
//   stall                       pipeline hold while an op is outstanding
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_op,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              stall
);

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [15:0] LAST_WAIT = 16'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state, state_d;

  // Registered state and outputs, with their next-state values.
  logic [15:0]       cnt, cnt_d;
  logic              ld_q, ld_d;        // in-flight op is a load
  logic [2:0]        f3_q, f3_d;        // in-flight func3
  logic [1:0]        lo_q, lo_d;        // in-flight byte offset
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_be_d;
  logic [31:0]       mem_wdata_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [31:0]       rsp_data_d;

  // Request decode.
  logic        is_load, is_store, is_mem;
  logic        f3_legal, misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wrep;

  assign is_load  = (req_op == OP_LOAD);
  assign is_store = (req_op == OP_STORE);
  assign is_mem   = is_load | is_store;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    req_be     = 4'b1111;
    req_wrep   = req_wdata;

    if (is_load) begin
      f3_legal = (req_func3 == 3'b000) || (req_func3 == 3'b001) ||
                 (req_func3 == 3'b010) || (req_func3 == 3'b100) ||
                 (req_func3 == 3'b101);
    end else begin
      f3_legal = (req_func3 == 3'b000) || (req_func3 == 3'b001) ||
                 (req_func3 == 3'b010);
    end

    // func3[1:0] selects the width for both signed and unsigned variants.
    case (req_func3[1:0])
      2'b00: begin
        req_be   = 4'b0001 << req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be     = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wrep   = {2{req_wdata[15:0]}};
        misaligned = req_addr[0];
      end
      default: begin
        req_be     = 4'b1111;
        req_wrep   = req_wdata;
        misaligned = (req_addr[1:0] != 2'b00);
      end
    endcase
  end

  // Load data extraction from the latched offset and func3.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    case (lo_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ld_d        = ld_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!is_mem) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = req_wdata;
            rsp_err_d   = 1'b0;
          end else if (!f3_legal || misaligned) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            cnt_d       = 16'd0;
            ld_d        = is_load;
            f3_d        = req_func3;
            lo_d        = req_addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = is_store ? req_wrep : 32'd0;
          end
        end
      end

      S_ACCESS: begin
        // An ack in the final wait cycle still completes the access.
        if (mem_ack) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ld_q ? rd_ext : 32'd0;
          rsp_err_d   = 1'b0;
        end else if (cnt == LAST_WAIT) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      ld_q      <= 1'b0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state     <= state_d;
      cnt       <= cnt_d;
      ld_q      <= ld_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE) | (req_valid & req_ready & is_mem);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//   Directed bench for lsu_mem_ctrl (MAX_WAIT = 4). Each operation pushes its
//   expected memory request and expected response into queues. A memory
//   responder pops the memory queue, checks the request and acks after the
//   entry's delay; a response monitor pops the response queue on rsp_valid.
//   The stimulus thread checks handshake timing, stall and reset behaviour.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam int ADDR_W = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        req_op;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              stall;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk_data;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;     // wait cycles before ack, -1 = never ack
    int          exp_hi;    // expected mem_req high cycles when never acked, -1 = skip
    bit          late_ack;  // pulse ack after the request has been dropped
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_rsp(input logic [31:0] data, input logic err, input bit chk_data);
    rsp_t r;
    r.data = data; r.err = err; r.chk_data = chk_data;
    rsp_q.push_back(r);
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int delay, input int exp_hi, input bit late_ack);
    mem_t m;
    m.we = we; m.addr = addr; m.be = be; m.wdata = wdata; m.rdata = rdata;
    m.delay = delay; m.exp_hi = exp_hi; m.late_ack = late_ack;
    mem_q.push_back(m);
  endtask

  // Issue one op and check accept-time stall, stall hold and response latency
  // (cycles from the accept cycle to the rsp_valid cycle).
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat);
    int lat;
    int stall_lo;
    bit mem_op;
    mem_op = (op == OP_LOAD) || (op == OP_STORE);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    check("stall_at_accept", 32'(stall), 32'(mem_op));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    stall_lo = 0;
    forever begin
      @(negedge clk);
      if (!stall) stall_lo++;
      if (rsp_valid) break;
      lat++;
      if (lat > 50) break;
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("stall_held", 32'(stall_lo), 32'd0);
    @(negedge clk);
    check("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  // Memory responder.
  initial begin
    mem_t m;
    int   hi;
    int   waited;
    logic unstable;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", 32'(mem_req), 32'd0);
          for (int i = 0; i < 300 && mem_req; i++) @(negedge clk);
        end else begin
          m = mem_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(m.we));
          check("mem_addr", mem_addr, m.addr);
          check("mem_be", 32'(mem_be), 32'(m.be));
          check("mem_wdata", mem_wdata, m.wdata);
          hi = 1;
          waited = 0;
          unstable = 1'b0;
          while (m.delay < 0 || waited < m.delay) begin
            @(negedge clk);
            if (!mem_req) break;
            hi++;
            waited++;
            if (mem_we !== m.we || mem_addr !== m.addr || mem_be !== m.be || mem_wdata !== m.wdata)
              unstable = 1'b1;
            if (hi > 300) break;
          end
          check("mem_stable", 32'(unstable), 32'd0);
          if (m.delay >= 0) begin
            mem_ack = 1'b1;
            mem_rdata = m.rdata;
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 32'hA5A5A5A5;
            check("mem_req_released", 32'(mem_req), 32'd0);
          end else begin
            if (m.exp_hi >= 0) check("mem_req_cycles", 32'(hi), 32'(m.exp_hi));
            if (m.late_ack) begin
              mem_ack = 1'b1;
              mem_rdata = 32'h11111111;
              repeat (2) @(negedge clk);
              mem_ack = 1'b0;
            end
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          r = rsp_q.pop_front();
          if (r.chk_data) check("rsp_data", rsp_data, r.data);
          check("rsp_err", 32'(rsp_err), 32'(r.err));
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 7'd0; req_func3 = 3'd0; req_addr = '0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_mem_be", 32'(mem_be), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // LB 0x1003, ack in cycle 1: top byte 0x80 sign-extended.
    exp_mem(1'b0, 32'h1000, 4'b1000, 32'd0, 32'h80000000, 0, -1, 1'b0);
    exp_rsp(32'hFFFFFF80, 1'b0, 1'b1);
    issue(OP_LOAD, 3'b000, 32'h1003, 32'd0, 2);

    // LHU 0x2002, ack after 3 wait cycles (last allowed cycle).
    exp_mem(1'b0, 32'h2000, 4'b1100, 32'd0, 32'hBEEF1234, 3, -1, 1'b0);
    exp_rsp(32'h0000BEEF, 1'b0, 1'b1);
    issue(OP_LOAD, 3'b101, 32'h2002, 32'd0, 5);

    // SB 0x3001: byte lane 1, replicated data, zero response.
    exp_mem(1'b1, 32'h3000, 4'b0010, 32'hABABABAB, 32'h12345678, 1, -1, 1'b0);
    exp_rsp(32'd0, 1'b0, 1'b1);
    issue(OP_STORE, 3'b000, 32'h3001, 32'h000000AB, 3);

    // LW misaligned and store func3=011: immediate error, no memory access.
    exp_rsp(32'd0, 1'b1, 1'b0);
    issue(OP_LOAD, 3'b010, 32'h4002, 32'd0, 1);
    exp_rsp(32'd0, 1'b1, 1'b0);
    issue(OP_STORE, 3'b011, 32'h4000, 32'h55555555, 1);

    // Non-memory op passes wdata through.
    exp_rsp(32'hCAFEF00D, 1'b0, 1'b1);
    issue(OP_ALU, 3'b000, 32'h4000, 32'hCAFEF00D, 1);

    // LH 0x5002: upper half 0x8001 sign-extended.
    exp_mem(1'b0, 32'h5000, 4'b1100, 32'd0, 32'h80017FFF, 0, -1, 1'b0);
    exp_rsp(32'hFFFF8001, 1'b0, 1'b1);
    issue(OP_LOAD, 3'b001, 32'h5002, 32'd0, 2);

    // LBU 0x6002: lane 2 byte 0xC3 zero-extended.
    exp_mem(1'b0, 32'h6000, 4'b0100, 32'd0, 32'h00C30000, 0, -1, 1'b0);
    exp_rsp(32'h000000C3, 1'b0, 1'b1);
    issue(OP_LOAD, 3'b100, 32'h6002, 32'd0, 2);

    // SH 0x7002: upper lanes, half replicated.
    exp_mem(1'b1, 32'h7000, 4'b1100, 32'hABCDABCD, 32'd0, 2, -1, 1'b0);
    exp_rsp(32'd0, 1'b0, 1'b1);
    issue(OP_STORE, 3'b001, 32'h7002, 32'h1234ABCD, 4);

    // SW 0x8000 and LW 0x9000: full word.
    exp_mem(1'b1, 32'h8000, 4'b1111, 32'hDEADBEEF, 32'd0, 0, -1, 1'b0);
    exp_rsp(32'd0, 1'b0, 1'b1);
    issue(OP_STORE, 3'b010, 32'h8000, 32'hDEADBEEF, 2);
    exp_mem(1'b0, 32'h9000, 4'b1111, 32'd0, 32'h76543210, 0, -1, 1'b0);
    exp_rsp(32'h76543210, 1'b0, 1'b1);
    issue(OP_LOAD, 3'b010, 32'h9000, 32'd0, 2);

    // Misaligned LH and illegal load func3=111.
    exp_rsp(32'd0, 1'b1, 1'b0);
    issue(OP_LOAD, 3'b001, 32'h5001, 32'd0, 1);
    exp_rsp(32'd0, 1'b1, 1'b0);
    issue(OP_LOAD, 3'b111, 32'h5000, 32'd0, 1);

    // Timeout: mem_req high 4 cycles, error response, late ack ignored.
    exp_mem(1'b0, 32'hA000, 4'b1111, 32'd0, 32'd0, -1, 4, 1'b1);
    exp_rsp(32'd0, 1'b1, 1'b1);
    issue(OP_LOAD, 3'b010, 32'hA000, 32'd0, 5);
    repeat (4) @(negedge clk);
    check("late_ack_err_held", 32'(rsp_err), 32'd1);
    check("late_ack_data_held", rsp_data, 32'd0);
    check("late_ack_no_req", 32'(mem_req), 32'd0);

    // Reset in the 2nd ACCESS cycle: mem_req drops at once, no response.
    exp_mem(1'b0, 32'hB000, 4'b1111, 32'd0, 32'd0, -1, -1, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LOAD; req_func3 = 3'b010; req_addr = 32'hB000; req_wdata = 32'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_mem_req", 32'(mem_req), 32'd0);
    check("async_reset_rsp_err", 32'(rsp_err), 32'd0);
    check("async_reset_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_req_ready", 32'(req_ready), 32'd1);
    check("post_reset_stall", 32'(stall), 32'd0);
    check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);

    // Recovery: LB 0x1000 with a positive byte.
    exp_mem(1'b0, 32'h1000, 4'b0001, 32'd0, 32'h0000007F, 0, -1, 1'b0);
    exp_rsp(32'h0000007F, 1'b0, 1'b1);
    issue(OP_LOAD, 3'b000, 32'h1000, 32'd0, 2);

    repeat (5) @(negedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
